// File: rtl/switch_alloc_if.sv
// Handshake bundle between the five input buffers, the switch allocator and
// the crossbar/output-enable logic of the 5-port mesh router.
interface switch_alloc_if;
    logic       e_req, w_req, n_req, s_req, j_req;
    logic [2:0] e_dst, w_dst, n_dst, s_dst, j_dst;
    logic       e_tail, w_tail, n_tail, s_tail, j_tail;
    logic       E_rdy, W_rdy, N_rdy, S_rdy, Eject_rdy;
    logic [2:0] S_E, S_W, S_N, S_S, S_eject;
    logic       e_pop, w_pop, n_pop, s_pop, j_pop;

    modport master (
        output e_req, w_req, n_req, s_req, j_req,
        output e_dst, w_dst, n_dst, s_dst, j_dst,
        output e_tail, w_tail, n_tail, s_tail, j_tail,
        output E_rdy, W_rdy, N_rdy, S_rdy, Eject_rdy,
        input  S_E, S_W, S_N, S_S, S_eject,
        input  e_pop, w_pop, n_pop, s_pop, j_pop
    );

    modport slave (
        input  e_req, w_req, n_req, s_req, j_req,
        input  e_dst, w_dst, n_dst, s_dst, j_dst,
        input  e_tail, w_tail, n_tail, s_tail, j_tail,
        input  E_rdy, W_rdy, N_rdy, S_rdy, Eject_rdy,
        output S_E, S_W, S_N, S_S, S_eject,
        output e_pop, w_pop, n_pop, s_pop, j_pop
    );
endinterface

// File: rtl/switch_alloc.sv
// Wormhole switch allocator: per-output round-robin arbitration with the
// grant held until the owner's tail flit has been transferred.
module switch_alloc (
    input logic          clk,
    input logic          reset,
    switch_alloc_if.slave bus
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [2:0] NO_OWNER = 3'b111;

    logic [4:0] req_v;
    logic [4:0] tail_v;
    logic [4:0] rdy_v;
    logic [2:0] dst_v   [5];

    state_t     state   [5];
    logic [2:0] ptr     [5];
    logic [2:0] sel     [5];

    logic [4:0] cand    [5];
    logic [2:0] grant   [5];
    logic [4:0] pop_v;
    logic [4:0] rel_v;

    assign req_v  = {bus.j_req,  bus.s_req,  bus.n_req,  bus.w_req,  bus.e_req};
    assign tail_v = {bus.j_tail, bus.s_tail, bus.n_tail, bus.w_tail, bus.e_tail};
    assign rdy_v  = {bus.Eject_rdy, bus.S_rdy, bus.N_rdy, bus.W_rdy, bus.E_rdy};
    assign dst_v[0] = bus.e_dst;
    assign dst_v[1] = bus.w_dst;
    assign dst_v[2] = bus.n_dst;
    assign dst_v[3] = bus.s_dst;
    assign dst_v[4] = bus.j_dst;

    // Search upward from the slot after the last winner, wrapping 4 -> 0.
    function automatic logic [2:0] rr_pick(input logic [4:0] c, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] pick;
        pick = NO_OWNER;
        idx  = last;
        for (int k = 0; k < 5; k++) begin
            idx = (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
            if (pick == NO_OWNER && c[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        pop_v = '0;
        rel_v = '0;
        for (int x = 0; x < 5; x++) begin
            cand[x] = '0;
            for (int i = 0; i < 5; i++) begin
                cand[x][i] = req_v[i] && (dst_v[i] == 3'(x));
            end
            grant[x] = rr_pick(cand[x], ptr[x]);
            if (state[x] == LOCKED) begin
                for (int i = 0; i < 5; i++) begin
                    if (sel[x] == 3'(i) && cand[x][i] && rdy_v[x]) begin
                        pop_v[i] = !reset;
                        rel_v[x] = tail_v[i];
                    end
                end
            end
        end
    end

    // One IDLE/LOCKED machine per output; the lock is only released by a tail pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int x = 0; x < 5; x++) begin
                state[x] <= IDLE;
                ptr[x]   <= 3'd4;
                sel[x]   <= NO_OWNER;
            end
        end else begin
            for (int x = 0; x < 5; x++) begin
                case (state[x])
                    IDLE: begin
                        if (grant[x] != NO_OWNER) begin
                            state[x] <= LOCKED;
                            sel[x]   <= grant[x];
                            ptr[x]   <= grant[x];
                        end
                    end
                    LOCKED: begin
                        if (rel_v[x]) begin
                            state[x] <= IDLE;
                            sel[x]   <= NO_OWNER;
                        end
                    end
                    default: begin
                        state[x] <= IDLE;
                        sel[x]   <= NO_OWNER;
                    end
                endcase
            end
        end
    end

    assign bus.S_E     = sel[0];
    assign bus.S_W     = sel[1];
    assign bus.S_N     = sel[2];
    assign bus.S_S     = sel[3];
    assign bus.S_eject = sel[4];

    assign bus.e_pop = pop_v[0];
    assign bus.w_pop = pop_v[1];
    assign bus.n_pop = pop_v[2];
    assign bus.s_pop = pop_v[3];
    assign bus.j_pop = pop_v[4];

endmodule
